// File: rtl/soc_addr_map_pkg.sv
// Shared types and register-map helpers for the runtime address decoder.
// Rules are stored at the widest supported address/index width.
package soc_addr_map_pkg;

   localparam int unsigned ADDR_MAX_W = 64;
   localparam int unsigned IDX_MAX_W  = 8;

   localparam int unsigned FIELD_START = 0;
   localparam int unsigned FIELD_END   = 1;
   localparam int unsigned FIELD_CTRL  = 2;

   typedef struct packed {
      logic                  valid;
      logic [IDX_MAX_W-1:0]  idx;
      logic [ADDR_MAX_W-1:0] start_addr;
      logic [ADDR_MAX_W-1:0] end_addr;
   } rule_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SWAP
   } state_e;

   function automatic int unsigned reg_commit(input int unsigned n_rules);
      return n_rules * 4;
   endfunction

   function automatic int unsigned reg_status(input int unsigned n_rules);
      return n_rules * 4 + 1;
   endfunction

endpackage

// File: rtl/soc_addr_map_match.sv
// Combinational priority matcher: lowest-numbered valid rule wins.
// Ports: rules_i, addr_i, default_en_i/default_idx_i in; idx_o, err_o out.
module soc_addr_map_match
   import soc_addr_map_pkg::*;
#(
   parameter int unsigned AXI_AW  = 64,
   parameter int unsigned N_RULES = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  rule_t [N_RULES-1:0] rules_i,
   input  logic [AXI_AW-1:0]   addr_i,
   input  logic                default_en_i,
   input  logic [IDX_W-1:0]    default_idx_i,
   output logic [IDX_W-1:0]    idx_o,
   output logic                err_o
);

   logic [ADDR_MAX_W-1:0] w_addr;

   assign w_addr = ADDR_MAX_W'(addr_i);

   // Walk from the highest rule down so the lowest match is applied last.
   always_comb begin
      idx_o = default_en_i ? default_idx_i : '0;
      err_o = !default_en_i;
      for (int r = N_RULES - 1; r >= 0; r--) begin
         if (rules_i[r].valid &&
             rules_i[r].start_addr <= w_addr &&
             w_addr <= rules_i[r].end_addr) begin
            idx_o = rules_i[r].idx[IDX_W-1:0];
            err_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/soc_addr_map.sv
// Runtime-programmable address decoder with shadow/active rule banks.
// Ports: cfg req/gnt port, dec lookup pipeline, txn_done_i, irq_o.
module soc_addr_map
   import soc_addr_map_pkg::*;
#(
   parameter int unsigned AXI_AW          = 64,
   parameter int unsigned N_PORTS         = 8,
   parameter int unsigned N_RULES         = 8,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter bit          DEFAULT_EN      = 1'b1,
   parameter int unsigned DEFAULT_IDX     = 0,
   localparam int unsigned IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1),
   localparam int unsigned CFG_AW = $clog2(N_RULES * 4 + 2)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_req_i,
   input  logic              cfg_we_i,
   input  logic [CFG_AW-1:0] cfg_addr_i,
   input  logic [63:0]       cfg_wdata_i,
   output logic              cfg_gnt_o,
   output logic              cfg_rvalid_o,
   output logic [63:0]       cfg_rdata_o,
   input  logic              dec_valid_i,
   input  logic [AXI_AW-1:0] dec_addr_i,
   output logic              dec_ready_o,
   output logic              dec_valid_o,
   output logic [IDX_W-1:0]  dec_idx_o,
   output logic              dec_err_o,
   input  logic              dec_ready_i,
   input  logic              txn_done_i,
   output logic              irq_o
);

   localparam int unsigned RI_W = $clog2(N_RULES);
   localparam logic [CFG_AW-1:0] A_COMMIT = CFG_AW'(reg_commit(N_RULES));
   localparam logic [CFG_AW-1:0] A_STATUS = CFG_AW'(reg_status(N_RULES));
   localparam logic [IDX_W-1:0]  DEF_IDX  = IDX_W'(DEFAULT_IDX);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

   rule_t [N_RULES-1:0] r_shadow;
   rule_t [N_RULES-1:0] r_active;
   logic                r_sh_def_en;
   logic [IDX_W-1:0]    r_sh_def_idx;
   logic                r_ac_def_en;
   logic [IDX_W-1:0]    r_ac_def_idx;
   state_e              r_state;
   state_e              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_underflow;
   logic                r_cfg_rvalid;
   logic [63:0]         r_cfg_rdata;
   logic                r_dec_valid;
   logic [IDX_W-1:0]    r_dec_idx;
   logic                r_dec_err;

   logic [63:0]      w_rdata;
   logic [RI_W-1:0]  w_rule;
   logic [1:0]       w_field;
   logic             w_wr;
   logic             w_rd;
   logic             w_in_rules;
   logic             w_is_commit;
   logic             w_is_status;
   logic             w_commit_req;
   logic             w_swap;
   logic             w_ready;
   logic             w_accept;
   logic             w_under;
   logic [IDX_W-1:0] w_match_idx;
   logic             w_match_err;

   assign w_wr         = cfg_req_i && cfg_we_i;
   assign w_rd         = cfg_req_i && !cfg_we_i;
   assign w_rule       = cfg_addr_i[2 +: RI_W];
   assign w_field      = cfg_addr_i[1:0];
   assign w_in_rules   = cfg_addr_i < A_COMMIT;
   assign w_is_commit  = cfg_addr_i == A_COMMIT;
   assign w_is_status  = cfg_addr_i == A_STATUS;
   assign w_commit_req = w_wr && w_is_commit && cfg_wdata_i[0];
   assign w_swap       = r_state == SWAP;

   // Held low during reset so every output except the grant reads 0.
   assign w_ready  = rst_ni && (!r_dec_valid || dec_ready_i) &&
                     r_state == IDLE && r_cnt < CNT_MAX;
   assign w_accept = dec_valid_i && w_ready;
   assign w_under  = txn_done_i && !w_accept && r_cnt == '0;

   always_comb begin
      w_rdata = '0;
      unique case (1'b1)
         w_in_rules: begin
            unique case (w_field)
               2'(FIELD_START): w_rdata = r_shadow[w_rule].start_addr;
               2'(FIELD_END):   w_rdata = r_shadow[w_rule].end_addr;
               2'(FIELD_CTRL): begin
                  w_rdata[63]        = r_shadow[w_rule].valid;
                  w_rdata[IDX_W-1:0] = r_shadow[w_rule].idx[IDX_W-1:0];
               end
               default: ;
            endcase
         end
         w_is_commit: begin
            w_rdata[8]         = r_sh_def_en;
            w_rdata[16 +: IDX_W] = r_sh_def_idx;
         end
         w_is_status: begin
            w_rdata[32 +: CNT_W] = r_cnt;
            w_rdata[1]           = r_underflow;
            w_rdata[0]           = r_state != IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_shadow     <= '0;
         r_sh_def_en  <= DEFAULT_EN;
         r_sh_def_idx <= DEF_IDX;
      end else if (w_wr) begin
         unique case (1'b1)
            w_in_rules: begin
               unique case (w_field)
                  2'(FIELD_START):
                     r_shadow[w_rule].start_addr <= cfg_wdata_i;
                  2'(FIELD_END):
                     r_shadow[w_rule].end_addr <= cfg_wdata_i;
                  2'(FIELD_CTRL): begin
                     r_shadow[w_rule].valid <= cfg_wdata_i[63];
                     r_shadow[w_rule].idx   <=
                        IDX_MAX_W'(cfg_wdata_i[IDX_W-1:0]);
                  end
                  default: ;
               endcase
            end
            w_is_commit: begin
               r_sh_def_en  <= cfg_wdata_i[8];
               r_sh_def_idx <= cfg_wdata_i[16 +: IDX_W];
            end
            default: ;
         endcase
      end
   end

   // Non-blocking copy: a shadow write in the SWAP cycle is not carried over.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_active     <= '0;
         r_ac_def_en  <= DEFAULT_EN;
         r_ac_def_idx <= DEF_IDX;
      end else if (w_swap) begin
         r_active     <= r_shadow;
         r_ac_def_en  <= r_sh_def_en;
         r_ac_def_idx <= r_sh_def_idx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_commit_req) w_state_nxt = DRAIN;
         DRAIN:   if (r_cnt == '0) w_state_nxt = SWAP;
         SWAP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt       <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_accept && !txn_done_i) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_accept && txn_done_i && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_under) begin
            r_underflow <= 1'b1;
         end else if (w_wr && w_is_status && cfg_wdata_i[1]) begin
            r_underflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_dec_valid <= 1'b0;
         r_dec_idx   <= '0;
         r_dec_err   <= 1'b0;
      end else if (w_accept) begin
         r_dec_valid <= 1'b1;
         r_dec_idx   <= w_match_idx;
         r_dec_err   <= w_match_err;
      end else if (dec_ready_i) begin
         r_dec_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cfg_rvalid <= 1'b0;
         r_cfg_rdata  <= '0;
      end else begin
         r_cfg_rvalid <= cfg_req_i;
         r_cfg_rdata  <= w_rd ? w_rdata : '0;
      end
   end

   soc_addr_map_match #(
      .AXI_AW  (AXI_AW),
      .N_RULES (N_RULES),
      .IDX_W   (IDX_W)
   ) u_match (
      .rules_i       (r_active),
      .addr_i        (dec_addr_i),
      .default_en_i  (r_ac_def_en),
      .default_idx_i (r_ac_def_idx),
      .idx_o         (w_match_idx),
      .err_o         (w_match_err)
   );

   assign cfg_gnt_o    = cfg_req_i;
   assign cfg_rvalid_o = r_cfg_rvalid;
   assign cfg_rdata_o  = r_cfg_rdata;
   assign dec_ready_o  = w_ready;
   assign dec_valid_o  = r_dec_valid;
   assign dec_idx_o    = r_dec_idx;
   assign dec_err_o    = r_dec_err;
   assign irq_o        = r_underflow;

endmodule

// File: tb/tb_soc_addr_map.sv
// Directed self-checking bench for soc_addr_map.
// Vector table for lookups plus hand sequences for commit/drain/reset.
module tb_soc_addr_map;

   localparam logic [5:0] A_COMMIT = 6'd32;
   localparam logic [5:0] A_STATUS = 6'd33;

   logic        clk_i;
   logic        rst_ni;
   logic        cfg_req_i;
   logic        cfg_we_i;
   logic [5:0]  cfg_addr_i;
   logic [63:0] cfg_wdata_i;
   logic        cfg_gnt_o;
   logic        cfg_rvalid_o;
   logic [63:0] cfg_rdata_o;
   logic        dec_valid_i;
   logic [63:0] dec_addr_i;
   logic        dec_ready_o;
   logic        dec_valid_o;
   logic [2:0]  dec_idx_o;
   logic        dec_err_o;
   logic        dec_ready_i;
   logic        txn_done_i;
   logic        irq_o;

   soc_addr_map dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cfg_req_i    (cfg_req_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_gnt_o    (cfg_gnt_o),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .dec_valid_i  (dec_valid_i),
      .dec_addr_i   (dec_addr_i),
      .dec_ready_o  (dec_ready_o),
      .dec_valid_o  (dec_valid_o),
      .dec_idx_o    (dec_idx_o),
      .dec_err_o    (dec_err_o),
      .dec_ready_i  (dec_ready_i),
      .txn_done_i   (txn_done_i),
      .irq_o        (irq_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] addr;
      logic [2:0]  idx;
      logic        err;
   } vec_t;

   vec_t vt[8];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_wr(input logic [5:0] a, input logic [63:0] d);
      cfg_req_i   = 1'b1;
      cfg_we_i    = 1'b1;
      cfg_addr_i  = a;
      cfg_wdata_i = d;
      tick();
      cfg_req_i = 1'b0;
      cfg_we_i  = 1'b0;
   endtask

   task automatic cfg_rd(input logic [5:0] a, output logic [63:0] d);
      cfg_req_i  = 1'b1;
      cfg_we_i   = 1'b0;
      cfg_addr_i = a;
      #1;
      chk1("cfg_gnt", cfg_gnt_o, 1'b1);
      tick();
      cfg_req_i = 1'b0;
      chk1("cfg_rvalid", cfg_rvalid_o, 1'b1);
      d = cfg_rdata_o;
   endtask

   // One accepted lookup followed by its completion, so cnt is unchanged.
   task automatic lookup(input logic [63:0] a, output logic [2:0] idx,
                         output logic err);
      dec_valid_i = 1'b1;
      dec_addr_i  = a;
      #1;
      chk1("lk_ready", dec_ready_o, 1'b1);
      tick();
      dec_valid_i = 1'b0;
      chk1("lk_valid", dec_valid_o, 1'b1);
      idx = dec_idx_o;
      err = dec_err_o;
      txn_done_i = 1'b1;
      tick();
      txn_done_i = 1'b0;
   endtask

   task automatic commit(input logic [63:0] d);
      int n;
      cfg_wr(A_COMMIT, d);
      n = 0;
      while (!dec_ready_o && n < 40) begin
         tick();
         n++;
      end
      chk1("commit_done", dec_ready_o, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  idx;
      logic        err;
      logic [63:0] rd;

      rst_ni      = 1'b0;
      cfg_req_i   = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = '0;
      cfg_wdata_i = '0;
      dec_valid_i = 1'b0;
      dec_addr_i  = '0;
      dec_ready_i = 1'b1;
      txn_done_i  = 1'b0;

      vt[0] = '{64'h1010_0000, 3'd3, 1'b0};
      vt[1] = '{64'h1A00_0000, 3'd5, 1'b0};
      vt[2] = '{64'h102F_FFFF, 3'd3, 1'b0};
      vt[3] = '{64'h1000_0000, 3'd3, 1'b0};
      vt[4] = '{64'h1030_0000, 3'd5, 1'b0};
      vt[5] = '{64'h1FFF_FFFF, 3'd5, 1'b0};
      vt[6] = '{64'h0FFF_FFFF, 3'd0, 1'b1};
      vt[7] = '{64'h2000_0000, 3'd0, 1'b1};

      repeat (3) tick();
      chk1("rst_dec_valid", dec_valid_o, 1'b0);
      chk1("rst_ready", dec_ready_o, 1'b0);
      chk1("rst_irq", irq_o, 1'b0);
      chk1("rst_rvalid", cfg_rvalid_o, 1'b0);
      rst_ni = 1'b1;
      tick();
      chk1("post_rst_valid", dec_valid_o, 1'b0);
      chk("post_rst_idx", 64'(dec_idx_o), 64'd0);
      chk1("post_rst_ready", dec_ready_o, 1'b1);

      lookup(64'h1C00_0000, idx, err);
      chk("def_idx", 64'(idx), 64'd0);
      chk1("def_err", err, 1'b0);
      commit(64'h1);
      lookup(64'h1C00_0000, idx, err);
      chk("nodef_idx", 64'(idx), 64'd0);
      chk1("nodef_err", err, 1'b1);

      cfg_wr(6'd0, 64'h1000_0000);
      cfg_wr(6'd1, 64'h102F_FFFF);
      cfg_wr(6'd2, 64'h8000_0000_0000_0003);
      cfg_wr(6'd4, 64'h1000_0000);
      cfg_wr(6'd5, 64'h1FFF_FFFF);
      cfg_wr(6'd6, 64'h8000_0000_0000_0005);
      commit(64'h1);
      for (int i = 0; i < 8; i++) begin
         lookup(vt[i].addr, idx, err);
         chk($sformatf("vec%0d_idx", i), 64'(idx), 64'(vt[i].idx));
         chk1($sformatf("vec%0d_err", i), err, vt[i].err);
      end

      commit(64'h0002_0101);
      lookup(64'h2000_0000, idx, err);
      chk("dflt2_idx", 64'(idx), 64'd2);
      chk1("dflt2_err", err, 1'b0);
      cfg_rd(A_COMMIT, rd);
      chk("commit_rd", rd, 64'h0002_0100);

      cfg_wr(6'd2, 64'h8000_0000_0000_0006);
      lookup(64'h1010_0000, idx, err);
      chk("shadow_iso", 64'(idx), 64'd3);
      cfg_rd(6'd2, rd);
      chk("shadow_ctrl", rd, 64'h8000_0000_0000_0006);
      cfg_rd(6'd4, rd);
      chk("shadow_start1", rd, 64'h1000_0000);
      cfg_wr(6'd3, 64'hDEAD);
      cfg_rd(6'd3, rd);
      chk("reserved_rd", rd, 64'd0);
      cfg_rd(6'd40, rd);
      chk("oor_rd", rd, 64'd0);

      dec_valid_i = 1'b1;
      dec_addr_i  = 64'h1A00_0000;
      repeat (3) tick();
      dec_valid_i = 1'b0;
      cfg_wr(A_COMMIT, 64'h0002_0101);
      chk1("drain_ready", dec_ready_o, 1'b0);
      cfg_rd(A_STATUS, rd);
      chk("drain_status", rd, 64'h3_0000_0001);
      repeat (3) begin
         txn_done_i = 1'b1;
         tick();
      end
      txn_done_i = 1'b0;
      chk1("drain_cnt0", dec_ready_o, 1'b0);
      tick();
      chk1("swap_ready", dec_ready_o, 1'b0);
      tick();
      chk1("idle_ready", dec_ready_o, 1'b1);
      lookup(64'h1010_0000, idx, err);
      chk("new_map", 64'(idx), 64'd6);

      dec_valid_i = 1'b1;
      dec_addr_i  = 64'h1A00_0000;
      repeat (16) tick();
      chk1("max_full", dec_ready_o, 1'b0);
      dec_valid_i = 1'b0;
      txn_done_i  = 1'b1;
      tick();
      txn_done_i = 1'b0;
      chk1("max_less", dec_ready_o, 1'b1);
      dec_valid_i = 1'b1;
      txn_done_i  = 1'b1;
      tick();
      dec_valid_i = 1'b0;
      txn_done_i  = 1'b0;
      cfg_rd(A_STATUS, rd);
      chk("both_cnt15", rd, 64'hF_0000_0000);
      repeat (15) begin
         txn_done_i = 1'b1;
         tick();
      end
      chk1("cnt0_irq", irq_o, 1'b0);
      tick();
      txn_done_i = 1'b0;
      chk1("under_irq", irq_o, 1'b1);
      cfg_rd(A_STATUS, rd);
      chk("under_status", rd, 64'h2);
      cfg_wr(A_STATUS, 64'h2);
      chk1("clr_irq", irq_o, 1'b0);
      chk1("wr_rvalid", cfg_rvalid_o, 1'b1);
      chk("wr_rdata", cfg_rdata_o, 64'd0);

      dec_ready_i = 1'b0;
      dec_valid_i = 1'b1;
      dec_addr_i  = 64'h1A00_0000;
      tick();
      dec_addr_i = 64'h1010_0000;
      for (int i = 0; i < 5; i++) begin
         chk1("bp_valid", dec_valid_o, 1'b1);
         chk("bp_idx", 64'(dec_idx_o), 64'd5);
         chk1("bp_err", dec_err_o, 1'b0);
         chk1("bp_ready", dec_ready_o, 1'b0);
         tick();
      end
      dec_ready_i = 1'b1;
      #1;
      chk1("bp_release", dec_ready_o, 1'b1);
      tick();
      dec_valid_i = 1'b0;
      chk("bp_next_idx", 64'(dec_idx_o), 64'd6);
      cfg_rd(A_STATUS, rd);
      chk("bp_cnt", rd, 64'h2_0000_0000);

      cfg_wr(A_COMMIT, 64'h1);
      chk1("rdrain_ready", dec_ready_o, 1'b0);
      tick();
      rst_ni = 1'b0;
      #1;
      chk1("mid_rst_valid", dec_valid_o, 1'b0);
      chk("mid_rst_idx", 64'(dec_idx_o), 64'd0);
      chk1("mid_rst_err", dec_err_o, 1'b0);
      chk1("mid_rst_ready", dec_ready_o, 1'b0);
      chk1("mid_rst_irq", irq_o, 1'b0);
      chk1("mid_rst_rvalid", cfg_rvalid_o, 1'b0);
      chk("mid_rst_rdata", cfg_rdata_o, 64'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      chk1("rel_ready", dec_ready_o, 1'b1);
      cfg_rd(6'd2, rd);
      chk("rel_ctrl", rd, 64'd0);
      cfg_rd(A_COMMIT, rd);
      chk("rel_commit", rd, 64'h100);
      cfg_rd(A_STATUS, rd);
      chk("rel_status", rd, 64'd0);
      lookup(64'h1010_0000, idx, err);
      chk("rel_lk_idx", 64'(idx), 64'd0);
      chk1("rel_lk_err", err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/soc_addr_map.md
Name: soc_addr_map

Overview:
- Runtime-programmable address decoder for the SoC interconnect. It is the successor to the fixed, elaboration-time SoC address map.
- Holds N_RULES {start, end, port idx, valid} rules in a shadow bank, written over a simple req/gnt config port, and an active bank used for lookup.
- A COMMIT write atomically swaps shadow into active once all outstanding decoded transactions have completed.
- Sits in front of the crossbar's address routing. The decoded port index drives the crossbar's per-transaction destination select.

Parameters:
- AXI_AW, 64, address width [bit].
- N_PORTS, 8, number of destination ports; IDX_W = $clog2(N_PORTS), minimum 1.
- N_RULES, 8, number of rules; power of two, at least 2.
- MAX_OUTSTANDING, 16, in-flight decoded transactions allowed; CNT_W = $clog2(MAX_OUTSTANDING+1).
- DEFAULT_EN, 1, reset value of default-route enable.
- DEFAULT_IDX, 0, reset value of the default port index.
- CFG_AW, $clog2(N_RULES*4+2), config word-address width. Derived; do not override.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- cfg_req_i, in, 1, config access request.
- cfg_we_i, in, 1, 1 = write.
- cfg_addr_i, in, CFG_AW, word address.
- cfg_wdata_i, in, 64, write data.
- cfg_gnt_o, out, 1, grant; equals cfg_req_i (combinational).
- cfg_rvalid_o, out, 1, response valid, one cycle after grant.
- cfg_rdata_o, out, 64, read data; 0 for writes.
- dec_valid_i, in, 1, lookup request valid.
- dec_addr_i, in, AXI_AW, address to decode.
- dec_ready_o, out, 1, lookup accepted.
- dec_valid_o, out, 1, result valid.
- dec_idx_o, out, IDX_W, decoded port.
- dec_err_o, out, 1, no rule matched and default route disabled.
- dec_ready_i, in, 1, result consumed.
- txn_done_i, in, 1, one decoded transaction completed downstream.
- irq_o, out, 1, level; sticky underflow error.

Behaviour:
- Register map, word addresses. Rule r occupies r*4 + field:
  - field 0: START.
  - field 1: END, inclusive.
  - field 2: CTRL = {valid[63], idx[IDX_W-1:0]}.
  - field 3: reserved; reads 0, writes ignored.
- Control registers:
  - N_RULES*4 = COMMIT. Write bit0=1 requests commit. Bit8 = default_en and bits[16+:IDX_W] = default_idx, both staged into shadow. Reads return the shadow values.
  - N_RULES*4+1 = STATUS, read: {cnt[32+:CNT_W], underflow[1], commit_pending[0]}. A write with bit1=1 clears underflow.
  - Out-of-range addresses read 0; writes to them are ignored.
- Config reads return shadow contents, never active.
- Reset state:
  - Both banks: all rules invalid, start/end 0, default_en=DEFAULT_EN, default_idx=DEFAULT_IDX.
  - state=IDLE, cnt=0, underflow=0.
  - All outputs 0, except cfg_gnt_o, which follows cfg_req_i.
- Lookup:
  - Uses the active bank only.
  - Match is start <= addr <= end with valid=1. The lowest-numbered matching rule wins.
  - With no match: idx=default_idx and err=0 if default_en; otherwise idx=0 and err=1.
- Pipeline:
  - One register stage, latency 1 cycle from acceptance to dec_valid_o.
  - dec_ready_o = (!dec_valid_o || dec_ready_i) && state==IDLE && cnt < MAX_OUTSTANDING.
  - The output holds stable while dec_valid_o && !dec_ready_i.
- Outstanding counter:
  - +1 on lookup acceptance (dec_valid_i && dec_ready_o); -1 on txn_done_i.
  - Both in the same cycle: counter unchanged.
  - txn_done_i at cnt==0: counter stays 0 and underflow sets (sticky); irq_o = underflow.
- Commit FSM:
  - IDLE -> DRAIN on a COMMIT write with bit0=1. In DRAIN, dec_ready_o=0.
  - DRAIN -> SWAP when cnt==0; if cnt is already 0, the next cycle.
  - SWAP (1 cycle): active <= shadow, including default_en and default_idx. Then -> IDLE.
  - commit_pending=1 in DRAIN and SWAP.
  - A COMMIT write while not IDLE is ignored.
  - Shadow writes are accepted in any state. A write in the same cycle as SWAP lands in shadow only; it is not copied.
- Reset mid-commit aborts the commit; both banks return to reset contents.

Decomposition:
- soc_addr_map_pkg:
  - rule_t struct {valid, idx, start_addr, end_addr}.
  - Field offset constants FIELD_START/END/CTRL.
  - Functions reg_commit(n_rules) and reg_status(n_rules).
  - state_e {IDLE, DRAIN, SWAP}.
- Sub-module soc_addr_map_match: combinational priority matcher. Inputs are the rule array, addr, default_en and default_idx; outputs are idx and err. Instantiated once on the active bank.

Test Plan:
- Reset, then lookup 0x1C00_0000 -> 1 cycle later dec_valid_o=1, idx=DEFAULT_IDX(0), err=0. Then write COMMIT with default_en=0 and bit0=1; after commit, the same lookup -> err=1, idx=0.
- Program rule0 = [0x1000_0000, 0x102F_FFFF] idx 3 and rule1 = [0x1000_0000, 0x1FFF_FFFF] idx 5, then commit.
  - 0x1010_0000 -> idx 3 (rule0 wins overlap).
  - 0x1A00_0000 -> idx 5.
  - 0x102F_FFFF -> idx 3 (inclusive end).
- Shadow isolation: change rule0.idx to 6 without commit -> lookups still return 3; config read of CTRL returns 6.
- Issue 3 lookups (cnt=3), then write COMMIT -> dec_ready_o=0 and STATUS.commit_pending=1. Pulse txn_done_i 3 times -> SWAP 1 cycle after cnt reaches 0, then IDLE with dec_ready_o=1 and the new map active.
- MAX_OUTSTANDING=16:
  - 16 accepted lookups with no done -> dec_ready_o=0.
  - Simultaneous accept and done at cnt=15 -> cnt stays 15.
  - done at cnt=0 -> irq_o=1; writing STATUS bit1 clears it.
- Back-pressure: hold dec_ready_i=0 for 5 cycles -> dec_idx_o/dec_err_o stable and no new acceptance. Assert rst_ni low during DRAIN -> all outputs 0, state IDLE, all rules invalid.
